// File: rtl/osc_pkg.sv
// Shared types, default widths and channel-scan helpers for the oscillator measurement block.
package osc_pkg;

    localparam int unsigned MAX_CH            = 8;
    localparam int unsigned IDX_W             = 3;
    localparam int unsigned DEF_NUM_CH        = 4;
    localparam int unsigned DEF_CNT_W         = 20;
    localparam int unsigned DEF_WINDOW_CYCLES = 4096;
    localparam int unsigned DEF_SETTLE_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } next_ch_t;

    // Lowest set index strictly above cur; found=0 when none remain.
    function automatic next_ch_t next_enabled(input logic [MAX_CH-1:0] mask,
                                              input logic [IDX_W-1:0]  cur);
        next_ch_t r;
        r = '0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            if (!r.found && mask[i] && (IDX_W'(i) > cur)) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Lowest set index of the mask; found=0 for an empty mask.
    function automatic next_ch_t first_enabled(input logic [MAX_CH-1:0] mask);
        next_ch_t r;
        r = '0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            if (!r.found && mask[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/osc_gate_counter.sv
// Saturating tick counter for one gate window, with sticky overflow flag.
module osc_gate_counter
    import osc_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             tick,
    output logic [CNT_W-1:0] count_nxt_c,
    output logic             ovf_nxt_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic             ovf_q;

    // Next count: clear wins; otherwise count ticks and pin at the maximum.
    always_comb begin
        count_nxt_c = count_q;
        ovf_nxt_c   = ovf_q;
        if (clr) begin
            count_nxt_c = '0;
            ovf_nxt_c   = 1'b0;
        end else if (en && tick) begin
            if (count_q == CNT_MAX) begin
                ovf_nxt_c = 1'b1;
            end else begin
                count_nxt_c = count_q + CNT_W'(1);
            end
        end
    end

    // Count and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt_c;
            ovf_q   <= ovf_nxt_c;
        end
    end

endmodule

// File: rtl/osc_measure_ctrl.sv
// Scans enabled oscillator channels: select, settle, count ticks over a gate window, report.
module osc_measure_ctrl
    import osc_pkg::*;
#(
    parameter int unsigned NUM_CH        = DEF_NUM_CH,
    parameter int unsigned CNT_W         = DEF_CNT_W,
    parameter int unsigned WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned SEL_W         = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              start,
    input  logic              continuous,
    input  logic              osc_tick,
    output logic [SEL_W-1:0]  osc_sel,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_data,
    output logic [SEL_W-1:0]  res_ch,
    output logic              res_ovf
);

    localparam int unsigned CYC_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(WINDOW_CYCLES - 1);

    state_t            state_q, state_nxt;
    logic [SEL_W-1:0]  sel_q, sel_nxt;
    logic [NUM_CH-1:0] mask_q, mask_nxt;
    logic [CYC_W-1:0]  cyc_q, cyc_nxt;
    logic              busy_q;
    logic              res_valid_q, res_valid_nxt;
    logic [CNT_W-1:0]  res_data_q, res_data_nxt;
    logic [SEL_W-1:0]  res_ch_q, res_ch_nxt;
    logic              res_ovf_q, res_ovf_nxt;

    logic              cnt_clr_c;
    logic              cnt_en_c;
    logic              launch_c;
    logic [CNT_W-1:0]  cnt_nxt_c;
    logic              ovf_nxt_c;
    next_ch_t          first_c;
    next_ch_t          nxt_c;

    // Tick counter for the current gate window.
    osc_gate_counter #(
        .CNT_W (CNT_W)
    ) u_gate_counter (
        .clk         (clk),
        .rst         (rst),
        .clr         (cnt_clr_c),
        .en          (cnt_en_c),
        .tick        (osc_tick),
        .count_nxt_c (cnt_nxt_c),
        .ovf_nxt_c   (ovf_nxt_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state, channel walk, phase timing and result capture.
    always_comb begin
        state_nxt     = state_q;
        sel_nxt       = sel_q;
        mask_nxt      = mask_q;
        cyc_nxt       = cyc_q;
        res_valid_nxt = res_valid_q;
        res_data_nxt  = res_data_q;
        res_ch_nxt    = res_ch_q;
        res_ovf_nxt   = res_ovf_q;
        cnt_clr_c     = 1'b0;
        cnt_en_c      = 1'b0;
        launch_c      = 1'b0;
        first_c       = first_enabled(MAX_CH'(ch_enable));
        nxt_c         = next_enabled(MAX_CH'(mask_q), IDX_W'(sel_q));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    launch_c = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    cyc_nxt   = '0;
                    cnt_clr_c = 1'b1;
                    state_nxt = ST_GATE;
                end else begin
                    cyc_nxt = cyc_q + CYC_W'(1);
                end
            end
            ST_GATE: begin
                cnt_en_c = 1'b1;
                if (cyc_q == GATE_LAST) begin
                    // Capture the combinational next count so a tick in the last cycle is included.
                    cyc_nxt       = '0;
                    res_valid_nxt = 1'b1;
                    res_data_nxt  = cnt_nxt_c;
                    res_ch_nxt    = sel_q;
                    res_ovf_nxt   = ovf_nxt_c;
                    state_nxt     = ST_REPORT;
                end else begin
                    cyc_nxt = cyc_q + CYC_W'(1);
                end
            end
            ST_REPORT: begin
                if (res_valid_q && res_ready) begin
                    res_valid_nxt = 1'b0;
                    if (nxt_c.found) begin
                        sel_nxt   = SEL_W'(nxt_c.idx);
                        cyc_nxt   = '0;
                        state_nxt = ST_SETTLE;
                    end else if (continuous) begin
                        launch_c = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // New pass: freeze the enable mask and start at its lowest channel.
        if (launch_c) begin
            mask_nxt = ch_enable;
            if (first_c.found) begin
                sel_nxt   = SEL_W'(first_c.idx);
                cyc_nxt   = '0;
                state_nxt = ST_SETTLE;
            end else begin
                state_nxt = ST_IDLE;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            mask_q      <= '0;
            cyc_q       <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ch_q    <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            sel_q       <= sel_nxt;
            mask_q      <= mask_nxt;
            cyc_q       <= cyc_nxt;
            busy_q      <= (state_nxt != ST_IDLE);
            res_valid_q <= res_valid_nxt;
            res_data_q  <= res_data_nxt;
            res_ch_q    <= res_ch_nxt;
            res_ovf_q   <= res_ovf_nxt;
        end
    end

    assign osc_sel   = sel_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ch    = res_ch_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: doc/osc_measure_ctrl.md
Name: osc_measure_ctrl

Overview:
- Sequences frequency measurements of up to NUM_CH ring/opamp oscillators that share one tick counter.
- Drives the oscillator select mux and waits a settle period after each switch.
- Counts synchronized oscillator ticks over a fixed gate window of clk cycles, then presents each result on a valid/ready port.
- Sits between the oscillator mux/synchronizer and the LED/readout logic.

Parameters:
- NUM_CH, 4, number of oscillator channels (2..8).
- CNT_W, 20, tick counter / result width.
- WINDOW_CYCLES, 4096, gate length in clk cycles (≥1).
- SETTLE_CYCLES, 16, clk cycles ignored after osc_sel changes (≥1).
- SEL_W, $clog2(NUM_CH), width of the channel index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- ch_enable  in  NUM_CH  per-channel enable, sampled when each pass is launched.
- start  in  1  one-cycle pulse: launch one scan pass; ignored unless IDLE.
- continuous  in  1  when high, a finished pass relaunches automatically.
- osc_tick  in  1  one-cycle pulse per rising edge of the selected oscillator, already synchronized to clk.
- osc_sel  out  SEL_W  oscillator mux select.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  CNT_W  tick count for the window.
- res_ch  out  SEL_W  channel the result belongs to.
- res_ovf  out  1  tick count saturated.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - state=IDLE, osc_sel=0, busy=0.
  - res_valid=0, res_data=0, res_ch=0, res_ovf=0.
  - Internal counters and the enable snapshot are cleared.
- Reset mid-operation aborts the pass immediately; any pending result is discarded.
- States: IDLE → SETTLE → GATE → REPORT → (SETTLE | IDLE).
- IDLE:
  - On start=1 (or a continuous relaunch), snapshot ch_enable into the pass mask.
  - If the mask is 0, stay IDLE and ignore the request.
  - Otherwise set osc_sel to the lowest enabled index, clear the settle counter, go SETTLE on the next edge.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; osc_tick is ignored.
  - Then clear the tick counter and go GATE.
- GATE:
  - Lasts exactly WINDOW_CYCLES cycles; every cycle with osc_tick=1 increments the tick counter.
  - Counting saturates at 2^CNT_W−1 and sets a sticky ovf flag; no wrap-around.
  - At window end, register res_data=count, res_ch=osc_sel, res_ovf=ovf, assert res_valid, go REPORT.
  - A tick in the final gate cycle is included in the count.
- REPORT:
  - res_valid and the res_* outputs are held stable until res_valid & res_ready at a clk edge.
  - On that handshake edge: res_valid=0 and the next state is chosen:
    - Next enabled channel in the mask (ascending, strictly above the current index) exists: set osc_sel to it, go SETTLE.
    - Else, continuous=1: resnapshot ch_enable and relaunch as from IDLE, without an idle cycle. If the new mask is 0, go IDLE.
    - Else: go IDLE.
- Backpressure stalls the scan; no ticks are counted in REPORT.
- ch_enable changes during a pass take effect only at the next launch.
- start while busy is ignored.
- Dropping continuous mid-pass ends the run after the current pass.
- osc_sel changes only on the edge that enters SETTLE, so it is constant throughout SETTLE and GATE.
- Single-channel timing: the result appears exactly SETTLE_CYCLES+WINDOW_CYCLES+1 cycles after the start pulse edge, counting IDLE→SETTLE as 1.
- res_valid rises on the edge leaving GATE.

Decomposition:
- Shared package osc_pkg holds:
  - the state enum (ST_IDLE, ST_SETTLE, ST_GATE, ST_REPORT);
  - a next_enabled(mask, cur) function returning the next set index and a found bit;
  - default width constants.
- One natural sub-module: osc_gate_counter, a saturating CNT_W tick counter with clear, enable and ovf flag, instantiated once.
- The controller FSM stays in the top module.

Test Plan:
- NUM_CH=4, WINDOW_CYCLES=100, SETTLE_CYCLES=4, ch_enable=4'b0101, osc_tick every 4th cycle, res_ready=1, start pulse. Required: results for ch0 then ch2, res_data=25 each, res_ovf=0, then busy=0. osc_sel=0 during ch0 SETTLE/GATE and 2 for ch2.
- Ticks asserted only during SETTLE, none in GATE. Required: res_data=0. Then osc_tick=1 every cycle with CNT_W=6, WINDOW_CYCLES=100. Required: res_data=63, res_ovf=1.
- Hold res_ready=0 for 50 cycles after res_valid. Required: res_* outputs stable, osc_sel unchanged, no new SETTLE entered. Release res_ready. Required: next channel's SETTLE starts on the handshake edge.
- continuous=1, ch_enable=4'b1000. Required: ch3 results back-to-back, each exactly 4+100 cycles after the prior handshake when res_ready=1. Clear continuous. Required: IDLE after the current result.
- ch_enable=0 with a start pulse. Required: busy stays 0. start pulse while busy. Required: ignored, the scan sequence is unchanged.
- rst asserted mid-GATE and mid-REPORT. Required: next cycle all outputs equal reset values and res_valid=0. A subsequent start behaves as from a fresh reset.
